// File: rtl/mul_ctrl_pkg.sv
// Shared state encoding and counter sizing for the shift-add multiplier sequencer.
package mul_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Wide enough to hold WIDTH itself so the count never wraps mid-operation.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_iter_counter.sv
// Iteration counter for the multiplier sequencer: cleared on INIT, stepped once per shift.
module mul_iter_counter
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + ONE;
    end
  end

  // Pre-increment compare: the shift that sees this high is the final one.
  assign last = (r_count == LAST_VAL);

endmodule

// File: rtl/shift_add_mul_sequencer.sv
// Handshaked control FSM for the sequential shift-add multiplier datapath.
// Optional FAST_SHIFT_EN: skips CHECK once the multiplier register is all-zero.
//
// state | meaning
// IDLE  | waiting for start
// INIT  | load operands, clear accumulator and iteration count
// CHECK | sample multiplier LSB (and mplr_zero when fast shift is built)
// ADD   | add multiplicand into upper accumulator
// SHIFT | shift accumulator/multiplier right, count one iteration
// DONE  | one-cycle completion pulse
module shift_add_mul_sequencer
  import mul_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic lsb,
`ifdef FAST_SHIFT_EN
  input  logic mplr_zero,
`endif
  output logic init,
  output logic add,
  output logic SR,
  output logic busy,
  output logic done
);

  state_t r_state;
  state_t w_next;
  logic   w_last;
  logic   w_clear;
  logic   w_inc;

  assign w_clear = (r_state == INIT);
  assign w_inc   = (r_state == SHIFT);

  mul_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
    .clock (clock),
    .reset (reset),
    .clear (w_clear),
    .inc   (w_inc),
    .last  (w_last)
  );

`ifdef FAST_SHIFT_EN
  logic r_fast;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fast <= 1'b0;
    end else if (r_state == INIT) begin
      r_fast <= 1'b0;
    end else if ((r_state == CHECK) && mplr_zero) begin
      r_fast <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = INIT;
      INIT:  w_next = CHECK;
      CHECK: begin
`ifdef FAST_SHIFT_EN
        if (mplr_zero)  w_next = SHIFT;
        else if (lsb)   w_next = ADD;
        else            w_next = SHIFT;
`else
        if (lsb) w_next = ADD;
        else     w_next = SHIFT;
`endif
      end
      ADD:   w_next = SHIFT;
      SHIFT: begin
`ifdef FAST_SHIFT_EN
        if (w_last)      w_next = DONE;
        else if (r_fast) w_next = SHIFT;
        else             w_next = CHECK;
`else
        if (w_last) w_next = DONE;
        else        w_next = CHECK;
`endif
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign init = (r_state == INIT);
  assign add  = (r_state == ADD);
  assign SR   = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_shift_add_mul_sequencer.sv
// Scoreboard bench for shift_add_mul_sequencer at WIDTH=4; also builds with FAST_SHIFT_EN.
module tb_shift_add_mul_sequencer;

  localparam int W = 4;
`ifdef FAST_SHIFT_EN
  localparam int D_ZERO = 6;
  localparam int D_ONE  = 8;
`else
  localparam int D_ZERO = 9;
  localparam int D_ONE  = 10;
`endif
  localparam int D_1011 = 12;
  localparam int D_1111 = 13;

  typedef struct {
    int done_cyc;
    int adds;
    int srs;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic lsb;
  logic mplr_zero;
  logic init, add, SR, busy, done;

  logic [W-1:0] mult_val = '0;
  logic [W-1:0] r_mplr;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   add_cnt = 0;
  int   sr_cnt = 0;
  bit   idle_chk = 1'b0;
  exp_t exp_q[$];

  shift_add_mul_sequencer #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .lsb       (lsb),
`ifdef FAST_SHIFT_EN
    .mplr_zero (mplr_zero),
`endif
    .init      (init),
    .add       (add),
    .SR        (SR),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier register of the datapath, so lsb/mplr_zero follow the strobes.
  always @(posedge clock or negedge reset) begin
    if (!reset)    r_mplr <= '0;
    else if (init) r_mplr <= mult_val;
    else if (SR)   r_mplr <= r_mplr >> 1;
  end
  assign lsb       = r_mplr[0];
  assign mplr_zero = (r_mplr == '0);

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clock) begin
    if (!reset) begin
      add_cnt  = 0;
      sr_cnt   = 0;
      idle_chk = 1'b0;
    end else begin
      if (idle_chk) begin
        chk("busy_after_done", int'(busy), 0);
        idle_chk = 1'b0;
      end
      if (init) begin
        add_cnt = 0;
        sr_cnt  = 0;
      end
      if (add) add_cnt++;
      if (SR)  sr_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_edge", cyc, e.done_cyc);
          chk("add_pulses", add_cnt, e.adds);
          chk("sr_pulses", sr_cnt, e.srs);
          idle_chk = 1'b1;
        end
      end
    end
  end

  task automatic run_op(input logic [W-1:0] m, input int doff, input int na,
                        input int ns, output int s);
    exp_t e;
    @(negedge clock);
    mult_val = m;
    start    = 1'b1;
    s        = cyc + 1;
    e.done_cyc = s + doff;
    e.adds     = na;
    e.srs      = ns;
    exp_q.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clock);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(negedge clock);
  endtask

  initial begin
    int s;
    int n;
    exp_t e;

    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_init", int'(init), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);

    run_op(4'b1011, D_1011, 3, 4, s);
    chk("init_after_start", int'(init), 1);
    drain("drain_1011");

    run_op(4'b0000, D_ZERO, 0, 4, s);
    drain("drain_0000");

    run_op(4'b1111, D_1111, 4, 4, s);
    drain("drain_1111");

    run_op(4'b0001, D_ONE, 1, 4, s);
    drain("drain_0001");

    // Extra start pulses at relative edges 3 and 6 must be ignored.
    run_op(4'b1011, D_1011, 3, 4, s);
    while (cyc < s + 2) @(negedge clock);
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    while (cyc < s + 5) @(negedge clock);
    start = 1'b1;
    @(negedge clock) start = 1'b0;
    drain("drain_ignore");

    // Asynchronous reset while in ADD.
    run_op(4'b1011, D_1011, 3, 4, s);
    n = 0;
    while (!add && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("reached_add", int'(add), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_init", int'(init), 0);
    chk("arst_add", int'(add), 0);
    chk("arst_sr", int'(SR), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    exp_q.delete();
    @(negedge clock) reset = 1'b1;
    repeat (2) @(negedge clock);
    run_op(4'b1011, D_1011, 3, 4, s);
    drain("drain_after_reset");

    // start held for 30 sampling edges: a new run every D_ZERO+2 edges.
    @(negedge clock);
    mult_val = '0;
    start    = 1'b1;
    s        = cyc + 1;
    for (int k = 0; k * (D_ZERO + 2) <= 29; k++) begin
      e.done_cyc = s + k * (D_ZERO + 2) + D_ZERO;
      e.adds     = 0;
      e.srs      = 4;
      exp_q.push_back(e);
    end
    repeat (30) @(negedge clock);
    start = 1'b0;
    drain("drain_held_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
